// File: rtl/div_seq_if.sv
// Handshake bundle for the sequential divider: operand side (in_*) and
// result side (out_*), each with its own valid/ready pair.
interface div_seq_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      is_signed;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;
    logic                      overflow;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, is_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    // The divider itself.
    modport slave (
        input  in_valid, is_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned per operation.
// One quotient bit per cycle on magnitudes; signs are applied in FIXUP.
// Divide-by-zero and signed MIN/-1 skip the iteration and reach DONE two
// cycles after accept; normal operations take DIVIDEND_WIDTH+2 cycles.
module div_seq #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    div_seq_if.slave    bus
);
    localparam int W  = DIVIDEND_WIDTH;
    localparam int V  = DIVISOR_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Two's-complement negation helpers at both operand widths.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [V-1:0] neg_v(input logic [V-1:0] x);
        return ~x + {{(V-1){1'b0}}, 1'b1};
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   dvd_q, dvd_d;        // raw dividend, then its magnitude being shifted out
    logic [V-1:0]   dvs_q, dvs_d;        // raw divisor, then its magnitude
    logic           sgn_q, sgn_d;
    logic           qsign_q, qsign_d;
    logic           rsign_q, rsign_d;
    logic [V-1:0]   rem_q, rem_d;        // partial remainder (always < |divisor| between steps)
    logic [W-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dbz_pend_q, dbz_pend_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [V-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [V:0]     rem_shift_s;
    logic           rem_ge_s;

    // Next partial remainder candidate and trial-subtract decision.
    assign rem_shift_s = {rem_q, dvd_q[W-1]};
    assign rem_ge_s    = (rem_shift_s >= {1'b0, dvs_q});

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

    // Next-state and datapath decode for every state.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        sgn_d       = sgn_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        dbz_pend_d  = dbz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    dvd_d      = bus.dividend;
                    dvs_d      = bus.divisor;
                    sgn_d      = bus.is_signed;
                    in_ready_d = 1'b0;
                    state_d    = S_SETUP;
                end else begin
                    in_ready_d = 1'b1;
                end
            end

            S_SETUP: begin
                qsign_d = sgn_q & (dvd_q[W-1] ^ dvs_q[V-1]);
                rsign_d = sgn_q & dvd_q[W-1];
                dvd_d   = (sgn_q && dvd_q[W-1]) ? neg_w(dvd_q) : dvd_q;
                dvs_d   = (sgn_q && dvs_q[V-1]) ? neg_v(dvs_q) : dvs_q;
                if (dvs_q == {V{1'b0}}) begin
                    // Fixed result; FIXUP publishes it with no sign correction.
                    quo_d      = {W{1'b1}};
                    rem_d      = dvd_q[V-1:0];
                    qsign_d    = 1'b0;
                    rsign_d    = 1'b0;
                    dbz_pend_d = 1'b1;
                    ovf_pend_d = 1'b0;
                    state_d    = S_FIXUP;
                end else if (sgn_q && (dvd_q == {1'b1, {(W-1){1'b0}}}) &&
                             (dvs_q == {V{1'b1}})) begin
                    quo_d      = {1'b1, {(W-1){1'b0}}};
                    rem_d      = {V{1'b0}};
                    qsign_d    = 1'b0;
                    rsign_d    = 1'b0;
                    dbz_pend_d = 1'b0;
                    ovf_pend_d = 1'b1;
                    state_d    = S_FIXUP;
                end else begin
                    quo_d      = {W{1'b0}};
                    rem_d      = {V{1'b0}};
                    cnt_d      = CW'(W - 1);
                    dbz_pend_d = 1'b0;
                    ovf_pend_d = 1'b0;
                    state_d    = S_ITER;
                end
            end

            S_ITER: begin
                dvd_d = {dvd_q[W-2:0], 1'b0};
                if (rem_ge_s) begin
                    // True difference is below |divisor|, so the low V bits are exact.
                    rem_d = rem_shift_s[V-1:0] - dvs_q;
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_s[V-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end

            S_FIXUP: begin
                quotient_d  = qsign_q ? neg_w(quo_q) : quo_q;
                remainder_d = rsign_q ? neg_v(rem_q) : rem_q;
                dbz_d       = dbz_pend_q;
                ovf_d       = ovf_pend_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            dvd_q       <= {W{1'b0}};
            dvs_q       <= {V{1'b0}};
            sgn_q       <= 1'b0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            rem_q       <= {V{1'b0}};
            quo_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            dbz_pend_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= {W{1'b0}};
            remainder_q <= {V{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            sgn_q       <= sgn_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            dbz_pend_q  <= dbz_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: a driver pushes reference-model results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_div_seq;
    localparam int W  = 32;
    localparam int V  = 32;
    localparam int W2 = 16;
    localparam int V2 = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
    int   last_acc = 0;
    bit   active = 1'b0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;

    div_seq_if #(.DIVIDEND_WIDTH(W),  .DIVISOR_WIDTH(V))  bus0 ();
    div_seq_if #(.DIVIDEND_WIDTH(W2), .DIVISOR_WIDTH(V2)) bus1 ();

    div_seq #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(V)) u_dut (
        .clk(clk), .reset(reset), .bus(bus0));
    div_seq #(.DIVIDEND_WIDTH(W2), .DIVISOR_WIDTH(V2)) u_dut16 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus0.out_ready = 1'b0;
            1:       bus0.out_ready = 1'b1;
            default: bus0.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer division truncating toward zero.
    function automatic void model(input bit sgn, input longint unsigned a_in,
                                  input longint unsigned b_in, input int w, input int v,
                                  output longint unsigned q, output longint unsigned r,
                                  output bit dbz, output bit ovf);
        longint unsigned mw, mv, a, b;
        longint sa, sb;
        mw = (64'd1 << w) - 64'd1;
        mv = (64'd1 << v) - 64'd1;
        a = a_in & mw;
        b = b_in & mv;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 64'd0) begin
            q = mw;
            r = a & mv;
            dbz = 1'b1;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(a);
            if ((a >> (w - 1)) != 64'd0) sa = sa - longint'(64'd1 << w);
            sb = longint'(b);
            if ((b >> (v - 1)) != 64'd0) sb = sb - longint'(64'd1 << v);
            if (sa == -longint'(64'd1 << (w - 1)) && sb == -64'sd1) begin
                q = a;
                r = 64'd0;
                ovf = 1'b1;
            end else begin
                q = $unsigned(sa / sb) & mw;
                r = $unsigned(sa % sb) & mv;
            end
        end
    endfunction

    // Drive one operation into the 32-bit divider; optionally score it.
    task automatic issue0(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        int n;
        exp_t e;
        longint unsigned q, r;
        bit dbz, ovf;
        @(posedge clk); #2;
        bus0.in_valid  = 1'b1;
        bus0.is_signed = sgn;
        bus0.dividend  = a;
        bus0.divisor   = b;
        n = 0;
        while (bus0.in_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        last_acc = cyc;
        #1;
        bus0.in_valid  = 1'b0;
        bus0.dividend  = $urandom;
        bus0.divisor   = $urandom;
        bus0.is_signed = $urandom_range(0, 1);
        if (push) begin
            model(sgn, 64'(a), 64'(b), W, V, q, r, dbz, ovf);
            e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
            e.lat = (dbz || ovf) ? 2 : W + 2;
            e.acc = last_acc;
            sb_q.push_back(e);
        end
    endtask

    // Result monitor: pops on each newly presented result, checks hold while stalled.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            active = 1'b0;
        end else if (bus0.out_valid === 1'b1) begin
            chk("in_ready_low_while_done", 64'(bus0.in_ready), 64'd0);
            if (!active) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 64'(bus0.quotient), 64'hDEAD_0000_0000_0000);
                end else begin
                    cur = sb_q.pop_front();
                    chk("quotient",    64'(bus0.quotient),    cur.q);
                    chk("remainder",   64'(bus0.remainder),   cur.r);
                    chk("div_by_zero", 64'(bus0.div_by_zero), 64'(cur.dbz));
                    chk("overflow",    64'(bus0.overflow),    64'(cur.ovf));
                    chk("latency",     64'(cyc - cur.acc),    64'(cur.lat));
                end
                active = 1'b1;
            end else begin
                chk("hold_quotient",  64'(bus0.quotient),  cur.q);
                chk("hold_remainder", 64'(bus0.remainder), cur.r);
            end
            if (bus0.out_ready === 1'b1) active = 1'b0;
        end else begin
            active = 1'b0;
        end
    end

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || bus0.in_ready !== 1'b1) && n < 5000) begin
            @(posedge clk); #3;
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_out_valid0();
        int n = 0;
        while (bus0.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("out_valid_timeout", 64'(n), 64'd0);
    endtask

    // Directed run on the 16/8 instance; out_ready held high there.
    task automatic run16(input bit sgn, input logic [15:0] a, input logic [7:0] b);
        int n, acc;
        longint unsigned q, r;
        bit dbz, ovf;
        model(sgn, 64'(a), 64'(b), W2, V2, q, r, dbz, ovf);
        @(posedge clk); #2;
        bus1.in_valid = 1'b1; bus1.is_signed = sgn; bus1.dividend = a; bus1.divisor = b;
        n = 0;
        while (bus1.in_ready !== 1'b1 && n < 200) begin @(posedge clk); #2; n++; end
        @(posedge clk); #1;
        acc = cyc;
        #1;
        bus1.in_valid = 1'b0; bus1.dividend = $urandom; bus1.divisor = $urandom;
        n = 0;
        while (bus1.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("w16_quotient",  64'(bus1.quotient),    q);
        chk("w16_remainder", 64'(bus1.remainder),   r);
        chk("w16_flags",     {62'd0, bus1.div_by_zero, bus1.overflow}, {62'd0, dbz, ovf});
        chk("w16_latency",   64'(cyc - acc), (dbz || ovf) ? 64'd2 : 64'(W2 + 2));
    endtask

    initial begin
        logic [31:0] a, b;
        int hs;
        reset = 1'b0;
        bus0.in_valid = 1'b0; bus0.is_signed = 1'b0; bus0.dividend = '0; bus0.divisor = '0;
        bus1.in_valid = 1'b0; bus1.is_signed = 1'b0; bus1.dividend = '0; bus1.divisor = '0;
        bus1.out_ready = 1'b1;
        #23;
        chk("reset_in_ready",  64'(bus0.in_ready),  64'd1);
        chk("reset_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("reset_quotient",  64'(bus0.quotient),  64'd0);
        chk("reset_flags",     {62'd0, bus0.div_by_zero, bus0.overflow}, 64'd0);
        reset = 1'b1;

        // Directed corner operations.
        rdy_mode = 1;
        issue0(1'b1, 32'd100, 32'd7, 1'b1);
        issue0(1'b1, -32'sd100, 32'd7, 1'b1);
        issue0(1'b1, 32'd7, -32'sd100, 1'b1);
        issue0(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue0(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue0(1'b0, 32'd1234, 32'd0, 1'b1);
        issue0(1'b1, -32'sd1234, 32'd0, 1'b1);
        issue0(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue0(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue0(1'b1, 32'h8000_0000, 32'd1, 1'b1);
        drain();

        // Back-pressure: result held, next operand waits for the handshake.
        rdy_mode = 0;
        issue0(1'b1, 32'd1000, -32'sd33, 1'b1);
        wait_out_valid0();
        hs = 0;
        fork
            issue0(1'b0, 32'd99, 32'd10, 1'b1);
            begin
                repeat (10) @(posedge clk);
                rdy_mode = 1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                        hs = cyc + 1;
                        break;
                    end
                end
            end
        join
        chk("accept_after_handshake", 64'(last_acc), 64'(hs + 1));
        drain();

        // Reset mid-iteration abandons the operation.
        issue0(1'b0, 32'd12345, 32'd17, 1'b0);
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("midreset_in_ready",  64'(bus0.in_ready),  64'd1);
        #20 reset = 1'b1;
        repeat (40) @(posedge clk);
        chk("midreset_no_result", 64'(bus0.out_valid), 64'd0);
        issue0(1'b0, 32'd50, 32'd5, 1'b1);
        drain();

        // Randomised traffic with random out_ready stalls.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'd0;
                default: a = $urandom;
            endcase
            issue0(1'($urandom_range(0, 1)), a, b, 1'b1);
        end
        drain();
        rdy_mode = 1;

        // Narrow build.
        run16(1'b1, -16'sd300, 8'd7);
        run16(1'b1, 16'h8000, 8'hFF);
        run16(1'b0, 16'd777, 8'd0);
        run16(1'b1, 16'h8000, 8'h80);
        for (int i = 0; i < 20; i++)
            run16(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(1, 255)));

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
